cv3_column_collector: RTL and testbench

- Receiving end of the convolution-channel column stream.
- Captures one PARALLEL_UNITS-wide output column per valid cycle into a ping-pong (two-bank) map buffer.
- Once a bank holds a full feature map (MAP_COLS columns), replays it column-by-column to the downstream pooling/next-layer stage over a valid/ready handshake.
- The upstream producer has no backpressure, so overruns are dropped and flagged.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/cv3_colbuf_2bank.sv | 28 ++
 rtl/cv3_column_collector.sv | 169 ++++++++++++++++
 tb/tb_cv3_column_collector.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN types and layer-1 geometry used by the convolution channel blocks.
package cnn_pkg;

    // FP16 element; the collector never interprets it, only moves it around.
    typedef logic [15:0] fp16_t;

    // Layer-1 geometry: output column height and columns per feature map.
    localparam int L1_COL_SIZE = 10;
    localparam int L1_MAP_COLS = 10;

    // Replay side of the column collector.
    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/cv3_colbuf_2bank.sv
// Two-bank column store: one registered write port, one combinational read port.
module cv3_colbuf_2bank #(
    parameter int DATA_WIDTH = 16,
    parameter int COL_SIZE   = 10,
    parameter int MAP_COLS   = 10
) (
    input  logic                                 clk,
    input  logic                                 wr_en,
    input  logic                                 wr_bank,
    input  logic [$clog2(MAP_COLS)-1:0]          wr_col,
    input  logic [COL_SIZE-1:0][DATA_WIDTH-1:0]  wr_data,
    input  logic                                 rd_bank,
    input  logic [$clog2(MAP_COLS)-1:0]          rd_col,
    output logic [COL_SIZE-1:0][DATA_WIDTH-1:0]  rd_data
);

    logic [COL_SIZE-1:0][DATA_WIDTH-1:0] mem [2][MAP_COLS];

    // Storage is not reset: contents only matter once a bank is marked full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_col] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_col];

endmodule

// File: rtl/cv3_column_collector.sv
// Column collector: captures producer columns into a ping-pong map buffer and
// replays each complete map downstream over a valid/ready handshake.
module cv3_column_collector
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(fp16_t),
    parameter int COL_SIZE   = L1_COL_SIZE,
    parameter int MAP_COLS   = L1_MAP_COLS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic [COL_SIZE-1:0][DATA_WIDTH-1:0]  col_in,
    input  logic                                 col_valid,
    output logic [COL_SIZE-1:0][DATA_WIDTH-1:0]  out_col,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic [$clog2(MAP_COLS)-1:0]          out_col_idx,
    output logic                                 overflow
);

    localparam int IDX_W = $clog2(MAP_COLS);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(MAP_COLS - 1);

    if (MAP_COLS < 2) begin : g_bad_map_cols
        $fatal(1, "cv3_column_collector: MAP_COLS must be at least 2");
    end

    rd_state_e                           state;
    logic [1:0]                          bank_full;
    logic [1:0]                          bank_full_nxt;
    logic                                wr_bank;
    logic                                rd_bank;
    logic [IDX_W-1:0]                    wr_col;
    logic [IDX_W-1:0]                    rd_col;
    logic [IDX_W-1:0]                    rd_addr;
    logic [COL_SIZE-1:0][DATA_WIDTH-1:0] rd_data;
    logic                                handshake;
    logic                                bank_release;
    logic                                wr_accept;
    logic                                wr_drop;
    logic                                wr_en;
    logic                                wr_map_done;

    // A bank frees up on the handshake of its last column; that same edge may
    // already accept a new column into it, so the release feeds wr_accept.
    assign handshake    = (state == RD_STREAM) && out_valid && out_ready;
    assign bank_release = handshake && out_last;
    assign wr_accept    = !bank_full[wr_bank] || (bank_release && (rd_bank == wr_bank));
    assign wr_drop      = col_valid && !wr_accept;
    assign wr_en        = col_valid && wr_accept && !clr;
    assign wr_map_done  = wr_en && (wr_col == LAST_COL);

    // IDLE always fetches column 0; STREAM pre-fetches the column after rd_col.
    assign rd_addr = ((state == RD_STREAM) && (rd_col != LAST_COL)) ? rd_col + IDX_W'(1) : '0;

    cv3_colbuf_2bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .COL_SIZE   (COL_SIZE),
        .MAP_COLS   (MAP_COLS)
    ) u_colbuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_col  (wr_col),
        .wr_data (col_in),
        .rd_bank (rd_bank),
        .rd_col  (rd_addr),
        .rd_data (rd_data)
    );

    // Write pointer advance and sticky overflow; a drop on a flush cycle still wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank  <= 1'b0;
            wr_col   <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_col   <= '0;
            overflow <= wr_drop;
        end else begin
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (wr_en) begin
                if (wr_col == LAST_COL) begin
                    wr_col  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_col <= wr_col + IDX_W'(1);
                end
            end
        end
    end

    // Full flags: release of the read bank and completion of the write bank are independent bits.
    always_comb begin
        bank_full_nxt = bank_full;
        if (bank_release) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
        if (wr_map_done) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
    end

    // Full-flag register; flush empties both banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= 2'b00;
        end else if (clr) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= bank_full_nxt;
        end
    end

    // Replay FSM: wait for a full bank, then present one column per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RD_IDLE;
            rd_bank     <= 1'b0;
            rd_col      <= '0;
            out_col     <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_col_idx <= '0;
        end else if (clr) begin
            state       <= RD_IDLE;
            rd_col      <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_col_idx <= '0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        out_col     <= rd_data;
                        out_valid   <= 1'b1;
                        out_last    <= 1'b0;
                        out_col_idx <= '0;
                        rd_col      <= '0;
                        state       <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (handshake) begin
                        if (out_last) begin
                            rd_bank     <= ~rd_bank;
                            rd_col      <= '0;
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            out_col_idx <= '0;
                            state       <= RD_IDLE;
                        end else begin
                            out_col     <= rd_data;
                            rd_col      <= rd_addr;
                            out_col_idx <= rd_addr;
                            out_last    <= (rd_addr == LAST_COL);
                        end
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cv3_column_collector.sv
// Self-checking bench for cv3_column_collector: a vector table for the basic
// single-map timing, directed multi-cycle sequences, and a randomized run,
// all compared against a queue-based model of the collector's behaviour.
module tb_cv3_column_collector;
    import cnn_pkg::*;

    localparam int COL_SIZE = 10;
    localparam int MAP_COLS = 10;
    localparam int IDX_W    = $clog2(MAP_COLS);
    localparam int CW       = COL_SIZE * 16;

    typedef fp16_t [COL_SIZE-1:0] col_t;

    typedef struct {
        logic cv;
        int   colNum;
        logic rdy;
        logic expValid;
        int   expIdx;
        logic expLast;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             clr;
    col_t             col_in;
    logic             col_valid;
    col_t             out_col;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [IDX_W-1:0] out_col_idx;
    logic             overflow;

    int errorCount = 0;
    int checkCount = 0;

    // Model: accepted-but-undelivered columns in arrival order, columns in the
    // map being filled, completed maps still occupying the buffer, and the
    // replay position.
    col_t accQ[$];
    int   fillCnt;
    int   heldMaps;
    logic mValid;
    int   mIdx;
    logic mOverflow;

    vec_t vecs[21];
    logic validHist[$];

    cv3_column_collector #(
        .DATA_WIDTH (16),
        .COL_SIZE   (COL_SIZE),
        .MAP_COLS   (MAP_COLS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .col_in      (col_in),
        .col_valid   (col_valid),
        .out_col     (out_col),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_col_idx (out_col_idx),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element (c, r) = 3C00 + c*16 + r.
    function automatic col_t patternCol(input int c);
        col_t v;
        for (int r = 0; r < COL_SIZE; r++) begin
            v[r] = 16'(32'h3C00 + c * 16 + r);
        end
        return v;
    endfunction

    function automatic col_t randCol();
        col_t v;
        for (int r = 0; r < COL_SIZE; r++) begin
            v[r] = 16'($urandom);
        end
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic boundFail(input string name);
        checkCount++;
        errorCount++;
        $display("[TB] FAIL %s: cycle budget expired (t=%0t)", name, $time);
    endtask

    task automatic applyStimulus(input logic cv, input col_t col, input logic rdy, input logic clrIn);
        col_valid = cv;
        col_in    = col;
        out_ready = rdy;
        clr       = clrIn;
    endtask

    task automatic modelReset();
        accQ.delete();
        fillCnt   = 0;
        heldMaps  = 0;
        mValid    = 1'b0;
        mIdx      = 0;
        mOverflow = 1'b0;
    endtask

    // One clock edge of the collector, stated in terms of maps and columns.
    task automatic modelEdge(input logic cv, input col_t col, input logic rdy, input logic clrIn);
        logic hs, rel, acc, drop;
        hs   = mValid && rdy;
        rel  = hs && (mIdx == MAP_COLS - 1);
        acc  = cv && ((heldMaps < 2) || rel);
        drop = cv && !acc;
        if (clrIn) begin
            accQ.delete();
            fillCnt   = 0;
            heldMaps  = 0;
            mValid    = 1'b0;
            mIdx      = 0;
            mOverflow = drop;
        end else begin
            if (drop) mOverflow = 1'b1;
            if (!mValid) begin
                if (heldMaps > 0) begin
                    mValid = 1'b1;
                    mIdx   = 0;
                end
            end else if (hs) begin
                void'(accQ.pop_front());
                if (rel) begin
                    mValid = 1'b0;
                    mIdx   = 0;
                end else begin
                    mIdx++;
                end
            end
            if (rel) heldMaps--;
            if (acc) begin
                accQ.push_back(col);
                if (fillCnt == MAP_COLS - 1) begin
                    fillCnt = 0;
                    heldMaps++;
                end else begin
                    fillCnt++;
                end
            end
        end
    endtask

    task automatic checkOutput();
        checkValue("out_valid", CW'(out_valid), CW'(mValid));
        checkValue("overflow", CW'(overflow), CW'(mOverflow));
        checkValue("out_last", CW'(out_last), CW'(mValid && (mIdx == MAP_COLS - 1)));
        if (mValid) begin
            checkValue("out_col_idx", CW'(out_col_idx), CW'(mIdx));
            checkValue("out_col", CW'(out_col), CW'(accQ[0]));
        end
    endtask

    task automatic stepCycle(input logic cv, input col_t col, input logic rdy, input logic clrIn);
        checkOutput();
        applyStimulus(cv, col, rdy, clrIn);
        @(posedge clk);
        modelEdge(cv, col, rdy, clrIn);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, "_valid"}, CW'(out_valid), '0);
        checkValue({tag, "_last"}, CW'(out_last), '0);
        checkValue({tag, "_idx"}, CW'(out_col_idx), '0);
        checkValue({tag, "_ovf"}, CW'(overflow), '0);
        checkValue({tag, "_col"}, CW'(out_col), '0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int firstV, lastV, zeros, ones;

        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        modelReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single map, out_ready high: ten captures, one load edge, ten handshakes.
        $display("[TB] single map vector table");
        for (int k = 0; k < 21; k++) begin
            vecs[k].cv       = (k < MAP_COLS);
            vecs[k].colNum   = k;
            vecs[k].rdy      = 1'b1;
            vecs[k].expValid = (k >= 10) && (k <= 19);
            vecs[k].expIdx   = vecs[k].expValid ? k - 10 : 0;
            vecs[k].expLast  = (k == 19);
        end
        for (int k = 0; k < 21; k++) begin
            applyStimulus(vecs[k].cv, patternCol(vecs[k].colNum), vecs[k].rdy, 1'b0);
            @(posedge clk);
            #1;
            checkValue("tbl_valid", CW'(out_valid), CW'(vecs[k].expValid));
            checkValue("tbl_last", CW'(out_last), CW'(vecs[k].expLast));
            checkValue("tbl_ovf", CW'(overflow), '0);
            if (vecs[k].expValid) begin
                checkValue("tbl_idx", CW'(out_col_idx), CW'(vecs[k].expIdx));
                checkValue("tbl_col", CW'(out_col), CW'(patternCol(vecs[k].expIdx)));
            end
        end

        // Backpressure: ready pattern 1,0,0 repeating.
        $display("[TB] backpressure");
        doReset();
        for (int k = 0; k < MAP_COLS; k++) stepCycle(1'b1, patternCol(k), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) stepCycle(1'b0, '0, ((k % 3) == 0), 1'b0);
        checkOutput();
        checkValue("bp_drained", CW'(out_valid), '0);

        // Ping-pong: twenty back-to-back columns, exactly one bubble between maps.
        $display("[TB] ping-pong");
        doReset();
        validHist.delete();
        for (int k = 0; k < 40; k++) begin
            stepCycle(k < 20, patternCol(k), 1'b1, 1'b0);
            validHist.push_back(out_valid);
        end
        checkOutput();
        firstV = -1; lastV = -1; zeros = 0; ones = 0;
        for (int k = 0; k < validHist.size(); k++) begin
            if (validHist[k] === 1'b1) begin
                if (firstV < 0) firstV = k;
                lastV = k;
                ones++;
            end
        end
        for (int k = firstV; (firstV >= 0) && (k <= lastV); k++) begin
            if (validHist[k] !== 1'b1) zeros++;
        end
        checkValue("pp_valid_cycles", CW'(ones), CW'(20));
        checkValue("pp_bubbles", CW'(zeros), CW'(1));

        // Overrun: both banks fill, columns 21..25 dropped, overflow from the 21st edge.
        $display("[TB] overrun");
        doReset();
        for (int k = 0; k < 25; k++) begin
            stepCycle(1'b1, patternCol(k), 1'b0, 1'b0);
            if (k == 19) checkValue("ovr_before_21", CW'(overflow), '0);
            if (k == 20) checkValue("ovr_at_21", CW'(overflow), CW'(1));
        end
        for (int k = 0; k < 30; k++) stepCycle(1'b0, '0, 1'b1, 1'b0);
        checkOutput();
        checkValue("ovr_sticky", CW'(overflow), CW'(1));

        // Release collision: a column arrives on bank 0's last handshake.
        $display("[TB] release collision");
        doReset();
        for (int k = 0; k < 20; k++) stepCycle(1'b1, patternCol(k), 1'b0, 1'b0);
        n = 0;
        while (!(mValid && (mIdx == MAP_COLS - 1)) && (n < 40)) begin
            stepCycle(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 40) boundFail("coll_reach_last");
        stepCycle(1'b1, patternCol(40), 1'b1, 1'b0);
        checkValue("coll_ovf", CW'(overflow), '0);
        for (int k = 1; k < MAP_COLS; k++) stepCycle(1'b1, patternCol(40 + k), 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) stepCycle(1'b0, '0, 1'b1, 1'b0);
        checkOutput();

        // Asynchronous reset in the middle of a stream.
        $display("[TB] reset mid-stream");
        doReset();
        for (int k = 0; k < MAP_COLS; k++) stepCycle(1'b1, patternCol(k), 1'b1, 1'b0);
        n = 0;
        while (!(mValid && (mIdx == 4)) && (n < 40)) begin
            stepCycle(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 40) boundFail("rst_reach_idx4");
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        doReset();
        for (int k = 0; k < MAP_COLS; k++) stepCycle(1'b1, patternCol(60 + k), 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) stepCycle(1'b0, '0, 1'b1, 1'b0);
        checkOutput();

        // Flush mid-stream, then a fresh map.
        $display("[TB] clr mid-stream");
        doReset();
        for (int k = 0; k < 20; k++) stepCycle(1'b1, patternCol(k), 1'b0, 1'b0);
        n = 0;
        while (!(mValid && (mIdx == 4)) && (n < 40)) begin
            stepCycle(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 40) boundFail("clr_reach_idx4");
        stepCycle(1'b0, '0, 1'b1, 1'b1);
        checkValue("clr_valid", CW'(out_valid), '0);
        checkValue("clr_ovf", CW'(overflow), '0);
        for (int k = 0; k < MAP_COLS; k++) stepCycle(1'b1, patternCol(80 + k), 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) stepCycle(1'b0, '0, 1'b1, 1'b0);
        checkOutput();

        // Flush versus a same-cycle drop: the drop keeps overflow set.
        $display("[TB] clr with drop");
        doReset();
        for (int k = 0; k < 21; k++) stepCycle(1'b1, patternCol(k), 1'b0, 1'b0);
        stepCycle(1'b1, patternCol(99), 1'b0, 1'b1);
        checkValue("clr_drop_ovf", CW'(overflow), CW'(1));
        stepCycle(1'b0, '0, 1'b0, 1'b1);
        checkValue("clr_nodrop_ovf", CW'(overflow), '0);
        checkOutput();

        // Randomized traffic against the model.
        $display("[TB] random traffic");
        doReset();
        for (int k = 0; k < 600; k++) begin
            stepCycle(($urandom_range(0, 99) < 70), randCol(), ($urandom_range(0, 99) < 60), 1'b0);
        end
        for (int k = 0; k < 60; k++) stepCycle(1'b0, '0, 1'b1, 1'b0);
        checkOutput();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
